// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-vector multiplier job arbiter.
package mm_pkg;

  // Arbiter job phases: wait for a request, first beat, W stream, X stream, result drain.
  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    LOAD_W,
    LOAD_X,
    DRAIN
  } arb_state_t;

  localparam int MM_W_WORDS = 64;
  localparam int MM_X_WORDS = 8;
  localparam int MM_Y_WORDS = 8;

  // Cyclic index arithmetic: (base + off) mod n, for base < n and off < n.
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, cyclically.
// The pointer register is owned by the caller.
module rr_arbiter
  import mm_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic            gnt_vld;
  logic [ID_W-1:0] idx;

  // Scan from the slot farthest from ptr back toward ptr so the nearest requester wins.
  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ID_W'(wrap_add(int'(ptr), k, N));
      if (req[idx]) begin
        gnt_id  = idx;
        gnt_vld = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign gnt[gi] = gnt_vld && (gnt_id == ID_W'(gi));
  end

endmodule

// File: rtl/mm_job_arbiter.sv
// Shares one 8x8 matrix-vector multiplier among several stream clients.
// A client owns the core for a whole job (optional W load, X load, results);
// the arbiter also remembers which client's W matrix is resident in the core.
module mm_job_arbiter
  import mm_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = 8,
  parameter int OUT_W       = 19,
  parameter int W_WORDS     = MM_W_WORDS,
  parameter int X_WORDS     = MM_X_WORDS,
  parameter int Y_WORDS     = MM_Y_WORDS,
  parameter int ID_W        = $clog2(NUM_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        cli_valid,
  input  logic [NUM_CLIENTS-1:0]        cli_new_matrix,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_data,
  output logic [NUM_CLIENTS-1:0]        cli_ready,
  output logic [NUM_CLIENTS-1:0]        cli_out_valid,
  input  logic [NUM_CLIENTS-1:0]        cli_out_ready,
  output logic [OUT_W-1:0]              cli_out_data,
  output logic                          mm_input_valid,
  output logic                          mm_new_matrix,
  output logic [DATA_W-1:0]             mm_data,
  input  logic                          mm_input_ready,
  input  logic                          mm_output_valid,
  input  logic [OUT_W-1:0]              mm_output_data,
  output logic                          mm_output_ready,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic [ID_W-1:0]               w_owner,
  output logic                          w_owner_vld,
  output logic                          stale_w_err
);

  localparam int BC_W = $clog2(W_WORDS + 1);
  localparam int OC_W = $clog2(Y_WORDS + 1);

  arb_state_t      state_reg;
  logic [ID_W-1:0] rr_ptr_reg;
  logic [ID_W-1:0] grant_id_reg;
  logic            busy_reg;
  logic [ID_W-1:0] w_owner_reg;
  logic            w_owner_vld_reg;
  logic            stale_w_err_reg;
  logic [BC_W-1:0] beat_cnt_reg;
  logic [OC_W-1:0] out_cnt_reg;

  logic [NUM_CLIENTS-1:0] arb_gnt;
  logic [ID_W-1:0]        arb_id;

  logic [DATA_W-1:0] cli_data_arr [NUM_CLIENTS];
  logic              sel_valid;
  logic              sel_new_matrix;
  logic              sel_out_ready;
  logic [DATA_W-1:0] sel_data;
  logic              fwd_phase;
  logic              drain_phase;
  logic              in_xfer;
  logic              out_xfer;

  rr_arbiter #(
    .N    (NUM_CLIENTS),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .req    (cli_valid),
    .ptr    (rr_ptr_reg),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
    assign cli_data_arr[gi]  = cli_data[gi*DATA_W +: DATA_W];
    assign cli_ready[gi]     = fwd_phase && (grant_id_reg == ID_W'(gi)) && mm_input_ready;
    assign cli_out_valid[gi] = drain_phase && (grant_id_reg == ID_W'(gi)) && mm_output_valid;
  end

  // Only the granted client is visible to the core; everything else is masked off.
  assign sel_valid      = cli_valid[grant_id_reg];
  assign sel_new_matrix = cli_new_matrix[grant_id_reg];
  assign sel_out_ready  = cli_out_ready[grant_id_reg];
  assign sel_data       = cli_data_arr[grant_id_reg];

  assign fwd_phase   = (state_reg == HEAD) || (state_reg == LOAD_W) || (state_reg == LOAD_X);
  assign drain_phase = (state_reg == DRAIN);

  assign mm_input_valid  = fwd_phase && sel_valid;
  assign mm_new_matrix   = fwd_phase && sel_new_matrix;
  assign mm_data         = fwd_phase ? sel_data : '0;
  // Outside DRAIN the core keeps its result because ready stays low.
  assign mm_output_ready = drain_phase && sel_out_ready;
  assign cli_out_data    = mm_output_data;

  assign in_xfer  = mm_input_valid && mm_input_ready;
  assign out_xfer = drain_phase && mm_output_valid && mm_output_ready;

  assign grant_id    = grant_id_reg;
  assign busy        = busy_reg;
  assign w_owner     = w_owner_reg;
  assign w_owner_vld = w_owner_vld_reg;
  assign stale_w_err = stale_w_err_reg;

  // Job sequencer: grant, count W/X beats and result handshakes, advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      grant_id_reg    <= '0;
      busy_reg        <= 1'b0;
      w_owner_reg     <= '0;
      w_owner_vld_reg <= 1'b0;
      stale_w_err_reg <= 1'b0;
      beat_cnt_reg    <= '0;
      out_cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|arb_gnt) begin
            grant_id_reg <= arb_id;
            busy_reg     <= 1'b1;
            state_reg    <= HEAD;
            beat_cnt_reg <= '0;
            out_cnt_reg  <= '0;
          end
        end
        HEAD: begin
          if (in_xfer) begin
            beat_cnt_reg <= BC_W'(1);
            out_cnt_reg  <= '0;
            if (sel_new_matrix) begin
              state_reg       <= LOAD_W;
              w_owner_reg     <= grant_id_reg;
              w_owner_vld_reg <= 1'b1;
            end else begin
              state_reg <= LOAD_X;
              // The job still runs, but against a W matrix some other client loaded.
              if (!w_owner_vld_reg || (w_owner_reg != grant_id_reg)) begin
                stale_w_err_reg <= 1'b1;
              end
            end
          end
        end
        LOAD_W: begin
          if (in_xfer) begin
            if (beat_cnt_reg == BC_W'(W_WORDS - 1)) begin
              state_reg    <= LOAD_X;
              beat_cnt_reg <= '0;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + BC_W'(1);
            end
          end
        end
        LOAD_X: begin
          if (in_xfer) begin
            if (beat_cnt_reg == BC_W'(X_WORDS - 1)) begin
              state_reg    <= DRAIN;
              beat_cnt_reg <= '0;
              out_cnt_reg  <= '0;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + BC_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            if (out_cnt_reg == OC_W'(Y_WORDS - 1)) begin
              state_reg    <= IDLE;
              busy_reg     <= 1'b0;
              out_cnt_reg  <= '0;
              beat_cnt_reg <= '0;
              rr_ptr_reg   <= ID_W'(wrap_add(int'(grant_id_reg), 1, NUM_CLIENTS));
            end else begin
              out_cnt_reg <= out_cnt_reg + OC_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Scoreboard bench for mm_job_arbiter with a behavioural multiplier-core model.
// Timing within each cycle: drivers update at negedge, handshakes are latched
// at negedge+1, the monitor checks at negedge+2, the test sequence acts at negedge+3.
module tb_mm_job_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int OW  = 19;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    cli_valid;
  logic [N-1:0]    cli_new_matrix;
  logic [N*DW-1:0] cli_data;
  logic [N-1:0]    cli_ready;
  logic [N-1:0]    cli_out_valid;
  logic [N-1:0]    cli_out_ready;
  logic [OW-1:0]   cli_out_data;
  logic            mm_input_valid;
  logic            mm_new_matrix;
  logic [DW-1:0]   mm_data;
  logic            mm_input_ready;
  logic            mm_output_valid;
  logic [OW-1:0]   mm_output_data;
  logic            mm_output_ready;
  logic [IDW-1:0]  grant_id;
  logic            busy;
  logic [IDW-1:0]  w_owner;
  logic            w_owner_vld;
  logic            stale_w_err;

  always #5 clk = ~clk;

  mm_job_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .cli_valid       (cli_valid),
    .cli_new_matrix  (cli_new_matrix),
    .cli_data        (cli_data),
    .cli_ready       (cli_ready),
    .cli_out_valid   (cli_out_valid),
    .cli_out_ready   (cli_out_ready),
    .cli_out_data    (cli_out_data),
    .mm_input_valid  (mm_input_valid),
    .mm_new_matrix   (mm_new_matrix),
    .mm_data         (mm_data),
    .mm_input_ready  (mm_input_ready),
    .mm_output_valid (mm_output_valid),
    .mm_output_data  (mm_output_data),
    .mm_output_ready (mm_output_ready),
    .grant_id        (grant_id),
    .busy            (busy),
    .w_owner         (w_owner),
    .w_owner_vld     (w_owner_vld),
    .stale_w_err     (stale_w_err)
  );

  typedef struct packed {
    logic [IDW-1:0] cli;
    logic           nm;
    logic [DW-1:0]  data;
  } beat_t;

  typedef struct packed {
    logic [IDW-1:0] cli;
    logic [OW-1:0]  data;
  } res_t;

  beat_t         cli_q [N][$];
  beat_t         exp_in [$];
  res_t          exp_out [$];
  logic [OW-1:0] core_out_q [$];

  int n_vec = 0;
  int n_err = 0;

  bit cli_gap_en  = 1'b0;
  bit out_gap_en  = 1'b0;
  bit core_gap_en = 1'b0;

  bit            in_flag [N];
  bit            mm_in_flag  = 1'b0;
  bit            mm_out_flag = 1'b0;
  logic          mm_in_nm;
  logic [DW-1:0] mm_in_data;
  int            core_left = 0;
  int            job_beats = 0;
  logic [DW-1:0] core_x [8];

  // Core result k: the k-th X word, the index and a fixed tag.
  function automatic logic [OW-1:0] core_fn(input logic [DW-1:0] x, input int k);
    return {x, 3'(k), 8'hA5};
  endfunction

  // Queue one job for client c and record its expected core beats and results.
  task automatic add_job(input int c, input bit nm, input logic [7:0] seed);
    int    n;
    beat_t b;
    res_t  r;
    n = nm ? 72 : 8;
    for (int j = 0; j < n; j++) begin
      b.cli  = IDW'(c);
      b.nm   = nm;
      b.data = 8'(int'(seed) + j * 3);
      cli_q[c].push_back(b);
      exp_in.push_back(b);
    end
    for (int k = 0; k < 8; k++) begin
      r.cli  = IDW'(c);
      r.data = core_fn(8'(int'(seed) + (n - 8 + k) * 3), k);
      exp_out.push_back(r);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!(exp_in.size() == 0 && exp_out.size() == 0 && !busy)) begin
      step();
      cyc++;
      if (cyc > 3000) begin
        n_vec++;
        n_err++;
        $display("FAIL %s timeout: in_left=%0d out_left=%0d busy=%0b", name, exp_in.size(), exp_out.size(), busy);
        finish_run();
      end
    end
  endtask

  task automatic wait_busy(input string name);
    int cyc;
    cyc = 0;
    while (!busy) begin
      step();
      cyc++;
      if (cyc > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL %s grant timeout: busy=%0b", name, busy);
        finish_run();
      end
    end
  endtask

  // Client drivers plus behavioural core: retire last cycle's handshakes, drive, latch handshakes.
  initial begin
    beat_t b;
    cli_valid       = '0;
    cli_new_matrix  = '0;
    cli_data        = '0;
    cli_out_ready   = '0;
    mm_input_ready  = 1'b0;
    mm_output_valid = 1'b0;
    mm_output_data  = '0;
    for (int c = 0; c < N; c++) in_flag[c] = 1'b0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (in_flag[c] && cli_q[c].size() > 0) b = cli_q[c].pop_front();
      end
      if (mm_in_flag) begin
        if (core_left == 0) core_left = mm_in_nm ? 72 : 8;
        if (core_left <= 8) core_x[8 - core_left] = mm_in_data;
        core_left--;
        job_beats++;
        if (core_left == 0) begin
          for (int k = 0; k < 8; k++) core_out_q.push_back(core_fn(core_x[k], k));
          job_beats = 0;
        end
      end
      if (mm_out_flag && core_out_q.size() > 0) void'(core_out_q.pop_front());

      for (int c = 0; c < N; c++) begin
        if (cli_q[c].size() > 0 && !(cli_gap_en && $urandom_range(0, 2) == 0)) begin
          cli_valid[c]          = 1'b1;
          cli_new_matrix[c]     = cli_q[c][0].nm;
          cli_data[c*DW +: DW]  = cli_q[c][0].data;
        end else begin
          cli_valid[c]          = 1'b0;
          cli_new_matrix[c]     = 1'b0;
        end
        cli_out_ready[c] = !(out_gap_en && $urandom_range(0, 2) == 0);
      end
      mm_input_ready  = !(core_gap_en && $urandom_range(0, 2) == 0);
      mm_output_valid = (core_out_q.size() > 0) && !(core_gap_en && $urandom_range(0, 2) == 0);
      mm_output_data  = (core_out_q.size() > 0) ? core_out_q[0] : '0;

      #1;
      for (int c = 0; c < N; c++) in_flag[c] = cli_valid[c] && cli_ready[c];
      mm_in_flag  = mm_input_valid && mm_input_ready;
      mm_in_nm    = mm_new_matrix;
      mm_in_data  = mm_data;
      mm_out_flag = mm_output_valid && mm_output_ready;
    end
  end

  // Monitor: pop and compare on every core-input beat and every client result handshake.
  initial begin
    beat_t e;
    res_t  r;
    bit    bad;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (mm_input_valid && mm_input_ready) begin
          n_vec++;
          if (exp_in.size() == 0) begin
            n_err++;
            $display("FAIL beat_unexpected: got cli=%0d data=%0h nm=%0b expected none", grant_id, mm_data, mm_new_matrix);
          end else begin
            e = exp_in.pop_front();
            if ({grant_id, mm_new_matrix, mm_data} !== e) begin
              n_err++;
              $display("FAIL beat: got cli=%0d nm=%0b data=%0h expected cli=%0d nm=%0b data=%0h",
                       grant_id, mm_new_matrix, mm_data, e.cli, e.nm, e.data);
            end
          end
        end
        for (int c = 0; c < N; c++) begin
          if (cli_out_valid[c] && cli_out_ready[c]) begin
            n_vec++;
            if (exp_out.size() == 0) begin
              n_err++;
              $display("FAIL result_unexpected: got cli=%0d data=%0h expected none", c, cli_out_data);
            end else begin
              r = exp_out.pop_front();
              if (IDW'(c) !== r.cli || cli_out_data !== r.data) begin
                n_err++;
                $display("FAIL result: got cli=%0d data=%0h expected cli=%0d data=%0h", c, cli_out_data, r.cli, r.data);
              end else begin
                $display("ok   result cli=%0d data=%0h", c, cli_out_data);
              end
            end
          end
        end
        bad = 1'b0;
        for (int c = 0; c < N; c++) begin
          if ((!busy || grant_id != IDW'(c)) && (cli_ready[c] || cli_out_valid[c])) bad = 1'b1;
        end
        if (!busy && (mm_input_valid || mm_output_ready)) bad = 1'b1;
        n_vec++;
        if (bad) begin
          n_err++;
          $display("FAIL mask: got busy=%0b grant=%0d cli_ready=%b cli_out_valid=%b mm_iv=%0b mm_or=%0b expected only granted client active",
                   busy, grant_id, cli_ready, cli_out_valid, mm_input_valid, mm_output_ready);
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_w_owner", 32'(w_owner), 32'd0);
    chk("rst_w_owner_vld", 32'(w_owner_vld), 32'd0);
    chk("rst_stale", 32'(stale_w_err), 32'd0);
    chk("rst_cli_ready", 32'(cli_ready), 32'd0);
    chk("rst_cli_out_valid", 32'(cli_out_valid), 32'd0);
    chk("rst_mm_out_ready", 32'(mm_output_ready), 32'd0);
    rst = 1'b0;

    // Client 0 loads W and runs X; pointer moves to 1.
    add_job(0, 1'b1, 8'h10);
    wait_busy("t1");
    chk("t1_grant_id", 32'(grant_id), 32'd0);
    wait_done("t1");
    chk("t1_w_owner", 32'(w_owner), 32'd0);
    chk("t1_w_owner_vld", 32'(w_owner_vld), 32'd1);
    chk("t1_stale", 32'(stale_w_err), 32'd0);

    // Client 1 runs X-only against client 0's W: flagged but forwarded.
    add_job(1, 1'b0, 8'h55);
    wait_busy("t3");
    chk("t3_grant_id", 32'(grant_id), 32'd1);
    wait_done("t3");
    chk("t3_stale", 32'(stale_w_err), 32'd1);
    chk("t3_w_owner", 32'(w_owner), 32'd0);

    // Reset in the middle of client 3's W load.
    add_job(3, 1'b1, 8'h20);
    cyc = 0;
    while (job_beats < 30) begin
      step();
      cyc++;
      if (cyc > 500) begin
        n_vec++;
        n_err++;
        $display("FAIL t5 beat30 timeout: got %0d beats expected 30", job_beats);
        finish_run();
      end
    end
    chk("t5_pre_busy", 32'(busy), 32'd1);
    chk("t5_pre_grant", 32'(grant_id), 32'd3);
    chk("t5_pre_w_owner", 32'(w_owner), 32'd3);
    rst = 1'b1;
    for (int c = 0; c < N; c++) begin
      cli_q[c].delete();
      in_flag[c] = 1'b0;
    end
    exp_in.delete();
    exp_out.delete();
    core_out_q.delete();
    mm_in_flag  = 1'b0;
    mm_out_flag = 1'b0;
    core_left   = 0;
    job_beats   = 0;
    step();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_w_owner_vld", 32'(w_owner_vld), 32'd0);
    chk("t5_stale", 32'(stale_w_err), 32'd0);
    chk("t5_cli_ready", 32'(cli_ready), 32'd0);
    chk("t5_grant_id", 32'(grant_id), 32'd0);
    rst = 1'b0;

    // Clients 0 and 2 at once with the pointer at 0: 0 first, then 2.
    add_job(0, 1'b1, 8'h30);
    add_job(2, 1'b1, 8'h70);
    wait_busy("t2");
    chk("t2_first_grant", 32'(grant_id), 32'd0);
    chk("t2_c2_ready", 32'(cli_ready[2]), 32'd0);
    wait_done("t2");
    chk("t2_w_owner", 32'(w_owner), 32'd2);
    chk("t2_stale", 32'(stale_w_err), 32'd0);

    // Random gaps on client valid, result ready and the core's handshakes.
    cli_gap_en  = 1'b1;
    out_gap_en  = 1'b1;
    core_gap_en = 1'b1;
    add_job(3, 1'b1, 8'h90);
    wait_done("t4a");
    add_job(3, 1'b0, 8'hC0);
    wait_done("t4b");
    cli_gap_en  = 1'b0;
    out_gap_en  = 1'b0;
    core_gap_en = 1'b0;
    chk("t4_w_owner", 32'(w_owner), 32'd3);
    chk("t4_stale", 32'(stale_w_err), 32'd0);

    // All clients requesting continuously, pointer at 0: grants 0,1,2,3,0.
    add_job(0, 1'b0, 8'h01);
    add_job(1, 1'b0, 8'h11);
    add_job(2, 1'b0, 8'h21);
    add_job(3, 1'b0, 8'h31);
    add_job(0, 1'b0, 8'h41);
    wait_done("t6");
    chk("t6_stale", 32'(stale_w_err), 32'd1);
    chk("t6_w_owner", 32'(w_owner), 32'd3);
    chk("t6_core_empty", 32'(core_out_q.size()), 32'd0);

    finish_run();
  end

endmodule
